// File: rtl/memtest_engine.sv
// memtest_engine: Wishbone-controlled four-pass (W0/R0/W1/R1) pattern test of a single-port SRAM.
// Progress/result code is driven on io_out; irq is high while the result is DONE or FAIL.
// Optional build macro MEMTEST_ADDR_XOR_EN folds the word address into the per-word data.
module memtest_engine #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [3:0]        sram_wmask,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic [7:0]        io_out,
    output logic [7:0]        io_oeb,
    output logic              irq
);

`ifdef MEMTEST_ADDR_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    localparam logic [31:0] OFF_CTRL      = 32'h00;
    localparam logic [31:0] OFF_STATUS    = 32'h04;
    localparam logic [31:0] OFF_PATTERN   = 32'h08;
    localparam logic [31:0] OFF_LAST_ADDR = 32'h0C;
    localparam logic [31:0] OFF_FAIL_ADDR = 32'h10;
    localparam logic [31:0] OFF_FAIL_DATA = 32'h14;

    localparam logic [7:0] CODE_START = 8'h00;
    localparam logic [7:0] CODE_W0    = 8'h0A;
    localparam logic [7:0] CODE_R0    = 8'h14;
    localparam logic [7:0] CODE_W1    = 8'h1E;
    localparam logic [7:0] CODE_R1    = 8'h28;
    localparam logic [7:0] CODE_DONE  = 8'hFF;
    localparam logic [7:0] CODE_FAIL  = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE, S_W0, S_R0, S_W1, S_R1, S_FIN, S_DONE, S_FAIL
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   pattern;
    logic [ADDR_W-1:0]   last_addr;
    logic [ADDR_W-1:0]   fail_addr;
    logic [DATA_W-1:0]   fail_data;
    logic [ADDR_W-1:0]   cmp_addr;
    logic                rd_pend;
    logic [31:0]         rd_data;
    logic [31:0]         off;
    logic                wb_req;
    logic                wb_wr;
    logic                ctrl_wr;
    logic                start_req;
    logic                abort_req;
    logic                busy;
    logic [DATA_W-1:0]   wpat;
    logic [DATA_W-1:0]   rpat;
    logic                unused_sel;

    // Per-word data: base pattern, optionally XORed with the word address.
    function automatic logic [DATA_W-1:0] word_data(input logic [DATA_W-1:0] pat,
                                                    input logic [ADDR_W-1:0] a);
        return XOR_EN ? (pat ^ DATA_W'(a)) : pat;
    endfunction

    assign unused_sel = ^wbs_sel_i;
    assign sram_wmask = 4'hF;
    assign io_oeb     = 8'h00;

    assign off       = wbs_adr_i - BASE_ADR;
    assign wb_req    = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign wb_wr     = wb_req && wbs_we_i;
    assign ctrl_wr   = wb_wr && (off == OFF_CTRL);
    assign abort_req = ctrl_wr && wbs_dat_i[1];
    assign start_req = ctrl_wr && wbs_dat_i[0] && !wbs_dat_i[1];
    assign busy      = (state != S_IDLE) && (state != S_DONE) && (state != S_FAIL);
    assign wpat      = (state == S_W0) ? pattern : ~pattern;
    assign rpat      = (state == S_R0) ? pattern : ~pattern;

    // Register read mux.
    always_comb begin
        rd_data = 32'h0;
        case (off)
            OFF_STATUS:    rd_data = {16'h0, io_out, 5'h0, state == S_FAIL, state == S_DONE, busy};
            OFF_PATTERN:   rd_data = 32'(pattern);
            OFF_LAST_ADDR: rd_data = 32'(last_addr);
            OFF_FAIL_ADDR: rd_data = 32'(fail_addr);
            OFF_FAIL_DATA: rd_data = 32'(fail_data);
            default:       rd_data = 32'h0;
        endcase
    end

    // Wishbone slave: one-cycle ack pulse, registered read data, config writes blocked while busy.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            pattern   <= DATA_W'(32'h5555_AAAA);
            last_addr <= '1;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= 32'h0;
            if (wb_req && !wbs_we_i) begin
                wbs_dat_o <= rd_data;
            end
            if (wb_wr && !busy) begin
                if (off == OFF_PATTERN)   pattern   <= DATA_W'(wbs_dat_i);
                if (off == OFF_LAST_ADDR) last_addr <= wbs_dat_i[ADDR_W-1:0];
            end
        end
    end

    // Test sequencer: SRAM strobes, progress code, failure capture and irq all registered here.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            io_out    <= CODE_START;
            irq       <= 1'b0;
            sram_csb  <= 1'b1;
            sram_web  <= 1'b1;
            sram_addr <= '0;
            sram_din  <= '0;
            rd_pend   <= 1'b0;
            cmp_addr  <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            rd_pend <= 1'b0;
            if (abort_req) begin
                state    <= S_IDLE;
                io_out   <= CODE_START;
                irq      <= 1'b0;
                sram_csb <= 1'b1;
                sram_web <= 1'b1;
            end else if (start_req && !busy) begin
                state     <= S_W0;
                io_out    <= CODE_START;
                irq       <= 1'b0;
                sram_csb  <= 1'b0;
                sram_web  <= 1'b0;
                sram_addr <= '0;
                sram_din  <= word_data(pattern, ADDR_W'(0));
                fail_addr <= '0;
                fail_data <= '0;
            end else begin
                case (state)
                    S_W0, S_W1: begin
                        if (sram_addr == last_addr) begin
                            state     <= (state == S_W0) ? S_R0 : S_R1;
                            io_out    <= (state == S_W0) ? CODE_W0 : CODE_W1;
                            sram_web  <= 1'b1;
                            sram_addr <= '0;
                        end else begin
                            sram_addr <= sram_addr + ADDR_W'(1);
                            sram_din  <= word_data(wpat, sram_addr + ADDR_W'(1));
                        end
                    end
                    S_R0, S_R1: begin
                        if (rd_pend && (sram_dout != word_data(rpat, cmp_addr))) begin
                            state     <= S_FAIL;
                            io_out    <= CODE_FAIL;
                            irq       <= 1'b1;
                            sram_csb  <= 1'b1;
                            sram_web  <= 1'b1;
                            fail_addr <= cmp_addr;
                            fail_data <= sram_dout;
                        end else if (!sram_csb) begin
                            rd_pend  <= 1'b1;
                            cmp_addr <= sram_addr;
                            if (sram_addr == last_addr) begin
                                sram_csb <= 1'b1;
                            end else begin
                                sram_addr <= sram_addr + ADDR_W'(1);
                            end
                        end else if (state == S_R0) begin
                            state     <= S_W1;
                            io_out    <= CODE_R0;
                            sram_csb  <= 1'b0;
                            sram_web  <= 1'b0;
                            sram_addr <= '0;
                            sram_din  <= word_data(~pattern, ADDR_W'(0));
                        end else begin
                            state  <= S_FIN;
                            io_out <= CODE_R1;
                        end
                    end
                    S_FIN: begin
                        state  <= S_DONE;
                        io_out <= CODE_DONE;
                        irq    <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memtest_engine.sv
// tb_memtest_engine: directed scoreboard bench for memtest_engine with a behavioural SRAM model.
module tb_memtest_engine;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] R_CTRL = 32'h00, R_STAT = 32'h04, R_PAT = 32'h08;
    localparam logic [31:0] R_LAST = 32'h0C, R_FADR = 32'h10, R_FDAT = 32'h14;

`ifdef MEMTEST_ADDR_XOR_EN
    localparam logic [31:0] FAULT_DATA = 32'h5555_AAA7;
`else
    localparam logic [31:0] FAULT_DATA = 32'h5555_AAA2;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = 32'h0;
    logic [7:0]  io_out, io_oeb;
    logic        irq;

    memtest_engine dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
        .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int nvec = 0;
    int nfail = 0;
    int cycle = 0;
    int io_ref = 0;
    int acc_hi = 0;
    bit mon_en = 0;
    bit fault_en = 0;
    bit alias_en = 0;
    logic [7:0] prev_io;

    logic [32:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [7:0]  io_code_q[$];
    int          io_dly_q[$];

    logic [31:0] mem [256];

    always @(posedge wb_clk_i) cycle <= cycle + 1;

    function automatic logic [7:0] phys(input logic [7:0] a);
        return (alias_en && a == 8'd4) ? 8'd0 : a;
    endfunction

    // SRAM model: one-cycle read latency, optional stuck-at bit and address alias.
    always @(posedge wb_clk_i) begin
        if (!sram_csb) begin
            if (!sram_web) mem[phys(sram_addr)] <= sram_din & {{8{sram_wmask[3]}}, {8{sram_wmask[2]}}, {8{sram_wmask[1]}}, {8{sram_wmask[0]}}};
            else sram_dout <= (fault_en && sram_addr == 8'd5) ? (mem[phys(sram_addr)] & ~32'h8) : mem[phys(sram_addr)];
            if (sram_addr != 8'd0) acc_hi <= acc_hi + 1;
        end
    end

    // Monitor: pops the read scoreboard on every ack and the code scoreboard on every io_out change.
    always @(negedge wb_clk_i) begin
        logic [32:0] ent;
        string nm;
        int dly;
        logic [7:0] code;
        if (mon_en) begin
            if (wbs_ack_o) begin
                if (rd_exp_q.size() == 0) begin
                    nvec++; nfail++;
                    $display("FAIL spurious_ack: ack with no transaction outstanding");
                end else begin
                    ent = rd_exp_q.pop_front();
                    nm  = rd_name_q.pop_front();
                    if (ent[32]) begin
                        nvec++;
                        if (wbs_dat_o !== ent[31:0]) begin
                            nfail++;
                            $display("FAIL %s: read %h, required %h", nm, wbs_dat_o, ent[31:0]);
                        end
                    end
                end
            end
            if (io_out !== prev_io) begin
                nvec++;
                if (io_code_q.size() == 0) begin
                    nfail++;
                    $display("FAIL io_unexpected: io_out changed to %h at cycle %0d, no change expected", io_out, cycle);
                end else begin
                    code = io_code_q.pop_front();
                    dly  = io_dly_q.pop_front();
                    if (io_out !== code) begin
                        nfail++;
                        $display("FAIL io_code: io_out %h, required %h", io_out, code);
                    end else if (dly >= 0 && (cycle - io_ref) != dly) begin
                        nfail++;
                        $display("FAIL io_timing %h: after %0d cycles, required %0d", code, cycle - io_ref, dly);
                    end
                end
                io_ref = cycle;
            end
            prev_io = io_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input bit wr, input logic [31:0] off, input logic [31:0] d,
                           input bit rchk, input logic [31:0] exp, input string name, input bit mark);
        int lat;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = wr;
        wbs_adr_i = BASE + off; wbs_dat_i = d;
        rd_exp_q.push_back({rchk, exp});
        rd_name_q.push_back(name);
        if (mark) io_ref = cycle + 1;
        lat = 0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) lat = i;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        nvec++;
        if (lat != 1) begin
            nfail++;
            $display("FAIL %s_ack: ack latency %0d, required 1", name, lat);
            if (lat == 0) begin
                void'(rd_exp_q.pop_back());
                void'(rd_name_q.pop_back());
            end
        end
    endtask

    task automatic wb_wr(input logic [31:0] off, input logic [31:0] d, input string name, input bit mark);
        wb_xfer(1'b1, off, d, 1'b0, 32'h0, name, mark);
    endtask

    task automatic wb_rd(input logic [31:0] off, input logic [31:0] exp, input string name);
        wb_xfer(1'b0, off, 32'h0, 1'b1, exp, name, 1'b0);
    endtask

    task automatic exp_io(input logic [7:0] code, input int dly);
        io_code_q.push_back(code);
        io_dly_q.push_back(dly);
    endtask

    task automatic push_pass_seq(input int last, input bit from_idle);
        if (!from_idle) exp_io(8'h00, 0);
        exp_io(8'h0A, last + 1);
        exp_io(8'h14, last + 2);
        exp_io(8'h1E, last + 1);
        exp_io(8'h28, last + 2);
        exp_io(8'hFF, 1);
    endtask

    task automatic wait_irq(input string name, input int max);
        bit seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge wb_clk_i);
            if (irq) seen = 1;
        end
        nvec++;
        if (!seen) begin
            nfail++;
            $display("FAIL %s: irq low after %0d cycles, required high", name, max);
        end
    endtask

    task automatic wait_io(input logic [7:0] code, input int max);
        bit seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge wb_clk_i);
            if (io_out == code) seen = 1;
        end
        nvec++;
        if (!seen) begin
            nfail++;
            $display("FAIL wait_io: io_out %h, required %h within %0d cycles", io_out, code, max);
        end
    endtask

    task automatic drained(input string name);
        repeat (3) @(negedge wb_clk_i);
        chk({name, "_io_drained"}, 32'(io_code_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi0;
        // Reset state
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("rst_io_out", 32'(io_out), 32'h00);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_csb", 32'(sram_csb), 32'h1);
        chk("rst_io_oeb", 32'(io_oeb), 32'h00);
        wb_rst_i = 1'b0;
        prev_io = io_out;
        mon_en = 1'b1;
        wb_rd(R_PAT, 32'h5555_AAAA, "rst_pattern");
        wb_rd(R_LAST, 32'h0000_00FF, "rst_last_addr");
        wb_rd(R_STAT, 32'h0, "rst_status");
        wb_rd(R_FADR, 32'h0, "rst_fail_addr");
        wb_rd(32'h40, 32'h0, "unmapped_read");

        // Pass run, LAST_ADDR = 9
        wb_wr(R_LAST, 32'd9, "set_last9", 1'b0);
        wb_rd(R_LAST, 32'd9, "last_readback");
        push_pass_seq(9, 1'b1);
        wb_wr(R_CTRL, 32'h1, "start_pass", 1'b1);
        wait_irq("pass_irq", 200);
        wb_rd(R_STAT, 32'h0000_FF02, "pass_status");
        wb_rd(R_CTRL, 32'h0, "ctrl_reads_zero");
        drained("pass");

        // Stuck-at-0 bit 3 at address 5
        fault_en = 1'b1;
        exp_io(8'h00, 0);
        exp_io(8'h0A, 10);
        exp_io(8'hEE, 7);
        wb_wr(R_CTRL, 32'h1, "start_fault", 1'b1);
        wait_irq("fault_irq", 200);
        chk("fault_csb_idle", 32'(sram_csb), 32'h1);
        wb_rd(R_STAT, 32'h0000_EE04, "fault_status");
        wb_rd(R_FADR, 32'd5, "fault_addr");
        wb_rd(R_FDAT, FAULT_DATA, "fault_data");
        drained("fault");
        fault_en = 1'b0;

        // Abort during R0; START and PATTERN writes while busy are ignored
        exp_io(8'h00, 0);
        exp_io(8'h0A, 10);
        exp_io(8'h00, -1);
        wb_wr(R_CTRL, 32'h1, "start_abort", 1'b1);
        wb_wr(R_CTRL, 32'h1, "start_busy", 1'b0);
        wb_wr(R_PAT, 32'h1234_5678, "pattern_busy", 1'b0);
        wait_io(8'h0A, 40);
        wb_wr(R_CTRL, 32'h3, "abort", 1'b0);
        chk("abort_csb", 32'(sram_csb), 32'h1);
        chk("abort_io_out", 32'(io_out), 32'h00);
        chk("abort_irq", 32'(irq), 32'h0);
        wb_rd(R_STAT, 32'h0, "abort_status");
        wb_rd(R_PAT, 32'h5555_AAAA, "pattern_unchanged");
        drained("abort");

        // LAST_ADDR = 0, then a back-to-back second run
        wb_wr(R_LAST, 32'd0, "set_last0", 1'b0);
        hi0 = acc_hi;
        push_pass_seq(0, 1'b1);
        wb_wr(R_CTRL, 32'h1, "start_b1", 1'b1);
        wait_irq("b1_irq", 50);
        wb_rd(R_STAT, 32'h0000_FF02, "b1_status");
        push_pass_seq(0, 1'b0);
        wb_wr(R_CTRL, 32'h1, "start_b2", 1'b1);
        wait_irq("b2_irq", 50);
        wb_rd(R_STAT, 32'h0000_FF02, "b2_status");
        drained("boundary");
        chk("only_addr0_accessed", 32'(acc_hi - hi0), 32'd0);

`ifdef MEMTEST_ADDR_XOR_EN
        // Address alias: addr 4 lands on addr 0, caught by the address-folded data
        wb_wr(R_LAST, 32'd9, "alias_last9", 1'b0);
        alias_en = 1'b1;
        exp_io(8'h00, 0);
        exp_io(8'h0A, 10);
        exp_io(8'hEE, 2);
        wb_wr(R_CTRL, 32'h1, "start_alias", 1'b1);
        wait_irq("alias_irq", 200);
        wb_rd(R_FADR, 32'd0, "alias_fail_addr");
        wb_rd(R_FDAT, 32'h5555_AAAE, "alias_fail_data");
        drained("alias");
        alias_en = 1'b0;
`endif

        chk("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
